// File: rtl/ethernet_rx_mmio_reader.sv
// Hardware RX drain engine: polls the Ethernet controller over MMIO, reads each
// received packet out of the RX buffer, streams it on valid/ready, then acks it.
module ethernet_rx_mmio_reader #(
    parameter int eth_mtu_p    = 2048,
    parameter int data_width_p = 32,
    parameter int poll_gap_p   = 16,
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            enable_i,
    output logic [13:0]                     mmio_addr_o,
    output logic                            mmio_read_en_o,
    output logic                            mmio_write_en_o,
    input  logic                            mmio_ready_and_i,
    output logic [1:0]                      mmio_op_size_o,
    output logic [31:0]                     mmio_write_data_o,
    input  logic                            mmio_valid_i,
    output logic                            mmio_ready_and_o,
    input  logic [31:0]                     mmio_read_data_i,
    input  logic                            mmio_decode_error_i,
    output logic [31:0]                     pkt_data_o,
    output logic                            pkt_v_o,
    input  logic                            pkt_ready_and_i,
    output logic                            pkt_last_o,
    output logic [2:0]                      pkt_last_bytes_o,
    output logic [packet_size_width_lp-1:0] pkt_len_o,
    output logic                            busy_o,
    output logic                            error_o
);
    localparam int W = packet_size_width_lp;
    localparam int gap_width_lp = $clog2(poll_gap_p + 1);
    localparam logic [13:0] ADDR_LEN  = 14'h1004;
    localparam logic [13:0] ADDR_PEND = 14'h1010;
    localparam logic [13:0] ADDR_IRQ  = 14'h1014;
    localparam logic [W-1:0] MTU_LP = W'(eth_mtu_p);
    localparam logic [gap_width_lp-1:0] GAP_LP = gap_width_lp'(poll_gap_p);

    typedef enum logic [3:0] {
        S_INIT_REQ, S_INIT_RSP, S_POLL_WAIT, S_POLL_REQ, S_POLL_RSP, S_LEN_REQ,
        S_LEN_RSP, S_DATA_REQ, S_DATA_RSP, S_CLR_REQ, S_CLR_RSP
    } state_e;

    state_e                    state_q;
    logic [13:0]               addr_q;
    logic                      rd_q, wr_q, dec_err_q, error_q;
    logic [data_width_p-1:0]   wdata_q, pkt_data_q;
    logic                      pkt_v_q, pkt_last_q;
    logic [2:0]                pkt_last_bytes_q;
    logic [W-1:0]              len_q, wcnt_q;
    logic [gap_width_lp-1:0]   gap_q;

    logic                      req_state, req_wr, rsp_state, consume, issue_ok;
    logic [13:0]               req_addr;
    logic [31:0]               req_data;
    state_e                    rsp_next;
    logic [W-1:0]              len_rd, last_word;
    logic                      len_bad, is_last;
    logic [2:0]                last_bytes;

    always_comb begin
        req_state = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 14'h0;
        req_data  = 32'h0;
        rsp_next  = state_q;
        case (state_q)
            S_INIT_REQ: begin req_state = 1'b1; req_wr = 1'b1; req_addr = ADDR_IRQ;  rsp_next = S_INIT_RSP; end
            S_POLL_REQ: begin req_state = 1'b1; req_addr = ADDR_PEND; rsp_next = S_POLL_RSP; end
            S_LEN_REQ:  begin req_state = 1'b1; req_addr = ADDR_LEN;  rsp_next = S_LEN_RSP;  end
            S_DATA_REQ: begin req_state = 1'b1; req_addr = 14'({wcnt_q, 2'b00}); rsp_next = S_DATA_RSP; end
            S_CLR_REQ:  begin req_state = 1'b1; req_wr = 1'b1; req_addr = ADDR_PEND; req_data = 32'h1;
                              rsp_next = S_CLR_RSP; end
            default: ;
        endcase
    end

    assign rsp_state = (state_q == S_INIT_RSP) || (state_q == S_POLL_RSP) || (state_q == S_LEN_RSP) ||
                       (state_q == S_DATA_RSP) || (state_q == S_CLR_RSP);
    assign mmio_ready_and_o = (state_q == S_DATA_RSP) ? (~pkt_v_q | pkt_ready_and_i) : rsp_state;
    assign consume = mmio_valid_i & mmio_ready_and_o;
    // A data read is only launched once the stream register can take its word.
    assign issue_ok = (state_q != S_DATA_REQ) | ~pkt_v_q | pkt_ready_and_i;

    assign len_rd     = mmio_read_data_i[W-1:0];
    assign len_bad    = (|mmio_read_data_i[data_width_p-1:W]) | (len_rd > MTU_LP);
    assign last_word  = (len_q - W'(1)) >> 2;
    assign is_last    = (wcnt_q == last_word);
    assign last_bytes = (len_q[1:0] == 2'b00) ? 3'd4 : {1'b0, len_q[1:0]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= S_INIT_REQ;
            addr_q           <= 14'h0;
            rd_q             <= 1'b0;
            wr_q             <= 1'b0;
            wdata_q          <= '0;
            dec_err_q        <= 1'b0;
            error_q          <= 1'b0;
            pkt_data_q       <= '0;
            pkt_v_q          <= 1'b0;
            pkt_last_q       <= 1'b0;
            pkt_last_bytes_q <= 3'd0;
            len_q            <= '0;
            wcnt_q           <= '0;
            gap_q            <= '0;
        end else begin
            if (pkt_ready_and_i) begin
                pkt_v_q          <= 1'b0;
                pkt_last_q       <= 1'b0;
                pkt_last_bytes_q <= 3'd0;
            end
            if (req_state) begin
                if (!(rd_q || wr_q)) begin
                    if (issue_ok) begin
                        addr_q  <= req_addr;
                        rd_q    <= ~req_wr;
                        wr_q    <= req_wr;
                        wdata_q <= req_data;
                    end
                end else if (mmio_ready_and_i) begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    state_q <= rsp_next;
                    if (mmio_decode_error_i) begin
                        error_q   <= 1'b1;
                        dec_err_q <= 1'b1;
                    end
                end
            end else if (rsp_state && consume && dec_err_q) begin
                dec_err_q <= 1'b0;
                gap_q     <= GAP_LP;
                state_q   <= S_POLL_WAIT;
            end else begin
                case (state_q)
                    S_INIT_RSP, S_CLR_RSP: if (consume) begin
                        gap_q   <= '0;
                        state_q <= S_POLL_WAIT;
                    end
                    S_POLL_WAIT: begin
                        if (enable_i && gap_q == '0) state_q <= S_POLL_REQ;
                        else if (gap_q != '0)        gap_q   <= gap_q - gap_width_lp'(1);
                    end
                    S_POLL_RSP: if (consume) begin
                        if (mmio_read_data_i[0]) state_q <= S_LEN_REQ;
                        else begin
                            gap_q   <= GAP_LP;
                            state_q <= S_POLL_WAIT;
                        end
                    end
                    S_LEN_RSP: if (consume) begin
                        len_q  <= len_rd;
                        wcnt_q <= '0;
                        if (mmio_read_data_i == 32'h0) state_q <= S_CLR_REQ;
                        else if (len_bad) begin
                            error_q <= 1'b1;
                            state_q <= S_CLR_REQ;
                        end else state_q <= S_DATA_REQ;
                    end
                    S_DATA_RSP: if (consume) begin
                        pkt_v_q          <= 1'b1;
                        pkt_data_q       <= mmio_read_data_i;
                        pkt_last_q       <= is_last;
                        pkt_last_bytes_q <= is_last ? last_bytes : 3'd0;
                        if (is_last) state_q <= S_CLR_REQ;
                        else begin
                            wcnt_q  <= wcnt_q + W'(1);
                            state_q <= S_DATA_REQ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mmio_addr_o       = addr_q;
    assign mmio_read_en_o    = rd_q;
    assign mmio_write_en_o   = wr_q;
    assign mmio_op_size_o    = 2'd2;
    assign mmio_write_data_o = wdata_q;
    assign pkt_data_o        = pkt_data_q;
    assign pkt_v_o           = pkt_v_q;
    assign pkt_last_o        = pkt_last_q;
    assign pkt_last_bytes_o  = pkt_last_bytes_q;
    assign pkt_len_o         = len_q;
    assign busy_o            = (state_q != S_POLL_WAIT) && (state_q != S_INIT_REQ);
    assign error_o           = error_q;
endmodule

// File: tb/tb_ethernet_rx_mmio_reader.sv
// Bench for ethernet_rx_mmio_reader: MMIO responder model plus a stream scoreboard.
module tb_ethernet_rx_mmio_reader;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic [13:0] mmio_addr;
    logic        rd_en, wr_en, rsp_rdy, mmio_rdy_o, dec_err;
    logic [1:0]  op_size;
    logic [31:0] wdata, rsp_data, pkt_data;
    logic        rsp_v, pkt_v, pkt_rdy, pkt_last, busy, err;
    logic [2:0]  pkt_lb;
    logic [11:0] pkt_len;

    always #5 clk = ~clk;

    ethernet_rx_mmio_reader dut (
        .clk_i(clk), .reset_i(rst), .enable_i(en),
        .mmio_addr_o(mmio_addr), .mmio_read_en_o(rd_en), .mmio_write_en_o(wr_en),
        .mmio_ready_and_i(rsp_rdy), .mmio_op_size_o(op_size), .mmio_write_data_o(wdata),
        .mmio_valid_i(rsp_v), .mmio_ready_and_o(mmio_rdy_o), .mmio_read_data_i(rsp_data),
        .mmio_decode_error_i(dec_err), .pkt_data_o(pkt_data), .pkt_v_o(pkt_v),
        .pkt_ready_and_i(pkt_rdy), .pkt_last_o(pkt_last), .pkt_last_bytes_o(pkt_lb),
        .pkt_len_o(pkt_len), .busy_o(busy), .error_o(err)
    );

    int n_vec = 0, n_miss = 0;
    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { bit wr; logic [13:0] addr; logic [31:0] data; int cyc; } req_t;
    typedef struct { logic [31:0] d; logic l; logic [2:0] lb; logic [11:0] len; } exp_t;
    req_t        req_log[$];
    exp_t        sb[$];
    logic [31:0] rxbuf [0:3];
    logic [31:0] len_reg = 32'h0;
    int          set_cnt = 0, clr_cnt, cyc_cnt;

    function automatic logic [31:0] model_read(input logic [13:0] a);
        if (a == 14'h1010) return {31'b0, set_cnt != clr_cnt};
        if (a == 14'h1004) return len_reg;
        return rxbuf[a[3:2]];
    endfunction

    assign dec_err = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Responder: one-cycle response latency, response held until consumed.
    always @(posedge clk) begin
        if (rst) rsp_v <= 1'b0;
        else begin
            if (rsp_v && mmio_rdy_o) rsp_v <= 1'b0;
            if ((rd_en || wr_en) && rsp_rdy) begin
                req_log.push_back('{wr_en, mmio_addr, wdata, cyc_cnt});
                rsp_v    <= 1'b1;
                rsp_data <= wr_en ? 32'h0 : model_read(mmio_addr);
                if (wr_en && mmio_addr == 14'h1010 && wdata[0]) clr_cnt <= clr_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ((rd_en || wr_en) && rsp_rdy) begin
                check_vec("one_outstanding", rsp_v, 0);
                check_vec("rd_wr_excl", rd_en & wr_en, 0);
            end
            if (pkt_v && pkt_rdy) begin
                if (sb.size() == 0) check_vec("stream_extra", pkt_v, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_vec("pkt_data", pkt_data, e.d);
                    check_vec("pkt_last", pkt_last, e.l);
                    check_vec("pkt_last_bytes", pkt_lb, e.lb);
                    check_vec("pkt_len", pkt_len, e.len);
                end
            end
        end
    end

    task automatic expect_req(input string tag, input bit wr, input logic [13:0] addr,
                              input logic [31:0] data, output int cyc);
        req_t r;
        int n = 0;
        cyc = -1;
        while (req_log.size() == 0 && n < 400) begin @(posedge clk); #1; n++; end
        if (req_log.size() == 0) check_vec({tag, "_timeout"}, req_log.size(), 1);
        else begin
            r   = req_log.pop_front();
            cyc = r.cyc;
            check_vec({tag, "_wr"}, r.wr, wr);
            check_vec({tag, "_addr"}, r.addr, addr);
            if (wr) check_vec({tag, "_wdata"}, r.data, data);
        end
    endtask

    task automatic load_pkt(input int len, input logic [31:0] w0, input logic [31:0] w1, input bit expect_out);
        exp_t e;
        int nw;
        rxbuf[0] = w0;
        rxbuf[1] = w1;
        len_reg  = len;
        if (expect_out && len > 0 && len <= 2048) begin
            nw = (len + 3) / 4;
            for (int i = 0; i < nw; i++) begin
                e.d   = (i == 0) ? w0 : w1;
                e.l   = (i == nw - 1);
                e.lb  = e.l ? 3'(((len % 4) == 0) ? 4 : (len % 4)) : 3'd0;
                e.len = len[11:0];
                sb.push_back(e);
            end
        end
    endtask

    // Consume one idle poll, then raise pending so the next poll sees it.
    task automatic start_pkt(input string tag);
        int c;
        expect_req({tag, "_idle_poll"}, 0, 14'h1010, 0, c);
        set_cnt++;
        expect_req({tag, "_pend"}, 0, 14'h1010, 0, c);
        expect_req({tag, "_len"}, 0, 14'h1004, 0, c);
    endtask

    task automatic wait_sb(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check_vec({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, n;
        rsp_rdy = 1'b1;
        pkt_rdy = 1'b1;
        rxbuf[2] = 32'h0;
        rxbuf[3] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_read_en", rd_en, 0);
        check_vec("rst_write_en", wr_en, 0);
        check_vec("rst_op_size", op_size, 2);
        check_vec("rst_addr", mmio_addr, 0);
        check_vec("rst_pkt_v", pkt_v, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_error", err, 0);
        rst = 1'b0;

        expect_req("init", 1, 14'h1014, 0, c0);
        expect_req("poll1", 0, 14'h1010, 0, c1);
        expect_req("poll2", 0, 14'h1010, 0, c2);
        check_vec("poll_gap_ok", (c2 - c1) >= 17, 1);

        load_pkt(6, 32'h11223344, 32'h55667788, 1);
        start_pkt("t6");
        expect_req("t6_d0", 0, 14'h0000, 0, c0);
        expect_req("t6_d1", 0, 14'h0004, 0, c0);
        expect_req("t6_clr", 1, 14'h1010, 1, c0);
        wait_sb("t6");

        load_pkt(8, 32'hA0A1A2A3, 32'hB0B1B2B3, 1);
        pkt_rdy = 1'b0;
        start_pkt("t8");
        expect_req("t8_d0", 0, 14'h0000, 0, c0);
        repeat (10) @(posedge clk);
        #1;
        check_vec("stall_no_read", req_log.size(), 0);
        check_vec("stall_pkt_v", pkt_v, 1);
        check_vec("stall_pkt_data", pkt_data, 32'hA0A1A2A3);
        pkt_rdy = 1'b1;
        expect_req("t8_d1", 0, 14'h0004, 0, c0);
        expect_req("t8_clr", 1, 14'h1010, 1, c0);
        wait_sb("t8");

        load_pkt(0, 32'h0, 32'h0, 1);
        start_pkt("t0");
        expect_req("t0_clr", 1, 14'h1010, 1, c0);
        check_vec("t0_error", err, 0);

        load_pkt(3000, 32'hEEEEEEEE, 32'hEEEEEEEE, 1);
        start_pkt("tbig");
        expect_req("tbig_clr", 1, 14'h1010, 1, c0);
        check_vec("tbig_error", err, 1);
        load_pkt(4, 32'hDEADBEEF, 32'h0, 1);
        start_pkt("t4");
        expect_req("t4_d0", 0, 14'h0000, 0, c0);
        expect_req("t4_clr", 1, 14'h1010, 1, c0);
        wait_sb("t4");
        check_vec("t4_error_sticky", err, 1);

        load_pkt(6, 32'h01020304, 32'h05060708, 0);
        start_pkt("trst");
        expect_req("trst_d0", 0, 14'h0000, 0, c0);
        n = 0;
        while (!pkt_v && n < 20) begin @(posedge clk); #1; n++; end
        check_vec("trst_word0_v", pkt_v, 1);
        check_vec("trst_no_d1_yet", req_log.size(), 0);
        rst = 1'b1;
        set_cnt = clr_cnt;
        @(posedge clk);
        #1;
        check_vec("trst_pkt_v", pkt_v, 0);
        check_vec("trst_pkt_last", pkt_last, 0);
        check_vec("trst_error", err, 0);
        check_vec("trst_read_en", rd_en, 0);
        rst = 1'b0;
        req_log.delete();
        expect_req("trst_init", 1, 14'h1014, 0, c0);
        expect_req("trst_poll", 0, 14'h1010, 0, c0);
        check_vec("trst_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
